// File: rtl/vga_sync_generator.sv
// 640x480@60 raster timing: column/row, syncs, enable and frame/vblank strobes.
// All outputs registered and mutually aligned; free-running, no backpressure.
module vga_sync_generator #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   CLK_DIV     = 1
) (
  input  logic        vga_clock,
  input  logic        reset,
  output logic [31:0] column,
  output logic [31:0] row,
  output logic        display_enable,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {VISIBLE, FRONT, SYNC, BACK} phase_t;

  localparam logic [31:0] H_TOTAL = 32'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [31:0] V_TOTAL = 32'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [31:0] H_FP    = 32'(H_VISIBLE);
  localparam logic [31:0] H_SP    = 32'(H_VISIBLE + H_FRONT);
  localparam logic [31:0] H_BP    = 32'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [31:0] V_FP    = 32'(V_VISIBLE);
  localparam logic [31:0] V_SP    = 32'(V_VISIBLE + V_FRONT);
  localparam logic [31:0] V_BP    = 32'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [2:0]  PRESC_LAST = 3'(CLK_DIV - 1);

  logic [2:0]  presc;
  logic        tick;
  logic        h_wrap;
  logic [31:0] column_nxt;
  logic [31:0] row_nxt;
  phase_t      h_state, v_state, h_state_nxt, v_state_nxt;

  // Phase advances when the position enters the first column/row of the next region.
  function automatic phase_t advance(input phase_t cur, input logic [31:0] pos,
                                     input logic [31:0] fp, input logic [31:0] sp,
                                     input logic [31:0] bp);
    advance = cur;
    case (cur)
      VISIBLE: if (pos == fp)    advance = FRONT;
      FRONT:   if (pos == sp)    advance = SYNC;
      SYNC:    if (pos == bp)    advance = BACK;
      BACK:    if (pos == 32'd0) advance = VISIBLE;
      default: advance = BACK;
    endcase
  endfunction

  always_comb begin
    tick        = (presc == PRESC_LAST);
    h_wrap      = (column == H_TOTAL - 32'd1);
    column_nxt  = h_wrap ? 32'd0 : column + 32'd1;
    row_nxt     = row;
    v_state_nxt = v_state;
    if (h_wrap) begin
      row_nxt     = (row == V_TOTAL - 32'd1) ? 32'd0 : row + 32'd1;
      v_state_nxt = advance(v_state, row_nxt, V_FP, V_SP, V_BP);
    end
    h_state_nxt = advance(h_state, column_nxt, H_FP, H_SP, H_BP);
  end

  // Reset parks at the last pixel of the frame so the first tick lands on (0,0).
  always_ff @(posedge vga_clock) begin
    if (!reset) begin
      presc          <= PRESC_LAST;
      column         <= H_TOTAL - 32'd1;
      row            <= V_TOTAL - 32'd1;
      h_state        <= BACK;
      v_state        <= BACK;
      display_enable <= 1'b0;
      vga_hsync      <= ~SYNC_ACTIVE;
      vga_vsync      <= ~SYNC_ACTIVE;
      frame_start    <= 1'b0;
      vblank_start   <= 1'b0;
      frame_count    <= 16'd0;
    end else begin
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      if (tick) begin
        presc          <= 3'd0;
        column         <= column_nxt;
        row            <= row_nxt;
        h_state        <= h_state_nxt;
        v_state        <= v_state_nxt;
        display_enable <= (h_state_nxt == VISIBLE) && (v_state_nxt == VISIBLE);
        vga_hsync      <= (h_state_nxt == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vga_vsync      <= (v_state_nxt == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        if (column_nxt == 32'd0 && row_nxt == 32'd0) begin
          frame_start <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end
        if (column_nxt == 32'd0 && row_nxt == V_FP)
          vblank_start <= 1'b1;
      end else begin
        presc <= presc + 3'd1;
      end
    end
  end

endmodule
